// File: rtl/dsi_long_packetizer_if.sv
// Avalon-ST word stream bundle used on both sides of the DSI packetizer.
// master drives the beat; slave returns ready.
`timescale 1ns/1ps
interface dsi_long_packetizer_if;
    logic [31:0] data;
    logic        valid;
    logic        startofpacket;
    logic        endofpacket;
    logic [1:0]  empty;
    logic        ready;

    modport master (
        output data, valid, startofpacket, endofpacket, empty,
        input  ready
    );

    modport slave (
        input  data, valid, startofpacket, endofpacket,
        output ready
    );
endinterface

// File: rtl/dsi_long_packetizer.sv
// Wraps packed pixel words into DSI long packets (DT 0x3E), one per line, plus VSS per frame.
// Payload CRC is generated only when DSI_PAYLOAD_CRC_EN is defined; otherwise the footer is zero.
`timescale 1ns/1ps
module dsi_long_packetizer #(
    parameter int         LINE_BYTES = 1440,
    parameter logic [1:0] VC         = 2'd0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    dsi_long_packetizer_if.slave         in_avl_st,
    dsi_long_packetizer_if.master        out_avl_st,
    output logic [1:0]                   err_flags
);

    localparam int LW = LINE_BYTES / 4;
    localparam int CW = $clog2(LW) + 1;
    localparam logic [CW-1:0] LAST = CW'(LW - 1);
    localparam logic [15:0]   WC   = 16'(LINE_BYTES);

    function automatic logic [7:0] ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]
             ^ d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]
             ^ d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]
             ^ d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]
             ^ d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]
             ^ d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]
             ^ d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    localparam logic [23:0] VSS_H = {16'h0000, VC, 6'h01};
    localparam logic [23:0] HDR_H = {WC, VC, 6'h3E};
    localparam logic [31:0] VSS_W = {ecc(VSS_H), VSS_H};
    localparam logic [31:0] HDR_W = {ecc(HDR_H), HDR_H};

    typedef enum logic [2:0] {
        S_IDLE, S_VSS, S_HDR, S_PAY, S_PAD, S_CRC
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           fend_q, fend_d;
    logic           first_q, first_d;
    logic [1:0]     err_q, err_d;
    logic           live_q;

    logic [31:0]    odata_q;
    logic           ovalid_q, osop_q, oeop_q;
    logic [1:0]     oempty_q;

    logic           free, in_rdy, accept;
    logic           ld, ld_sop, ld_eop;
    logic [31:0]    ld_data, footer;
    logic [1:0]     ld_empty;

`ifdef DSI_PAYLOAD_CRC_EN
    logic [15:0] crc_q, crc_d;

    // Reflected CCITT, data bits shifted in from bit 0 (byte 0 LSB first)
    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic [31:0] d
    );
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 32; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 16'h8408 : 16'h0000);
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (ld && state_q == S_HDR)
            crc_d = 16'hFFFF;
        else if (ld && (state_q == S_PAY || state_q == S_PAD))
            crc_d = crc_step(crc_q, ld_data);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= 16'hFFFF;
        else        crc_q <= crc_d;
    end

    assign footer = {16'h0000, crc_q};
`else
    assign footer = 32'h0000_0000;
`endif

    assign free   = ~ovalid_q | out_avl_st.ready;
    assign accept = in_avl_st.valid & in_rdy;

    // IDLE swallows stray non-SOP words; a SOP word waits for PAYLOAD
    always_comb begin
        in_rdy = 1'b0;
        unique case (state_q)
            S_IDLE:  in_rdy = live_q & ~in_avl_st.startofpacket;
            S_PAY:   in_rdy = free;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fend_d   = fend_q;
        first_d  = first_q;
        err_d    = err_q;
        ld       = 1'b0;
        ld_data  = 32'h0;
        ld_sop   = 1'b0;
        ld_eop   = 1'b0;
        ld_empty = 2'd0;
        unique case (state_q)
            S_IDLE: begin
                if (in_avl_st.valid && in_avl_st.startofpacket) begin
                    state_d = S_VSS;
                    first_d = 1'b1;
                end
            end
            S_VSS: begin
                if (free) begin
                    ld      = 1'b1;
                    ld_data = VSS_W;
                    ld_sop  = 1'b1;
                    ld_eop  = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (free) begin
                    ld      = 1'b1;
                    ld_data = HDR_W;
                    ld_sop  = 1'b1;
                    cnt_d   = '0;
                    fend_d  = 1'b0;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                if (accept) begin
                    ld      = 1'b1;
                    ld_data = in_avl_st.data;
                    cnt_d   = cnt_q + CW'(1);
                    first_d = 1'b0;
                    if (in_avl_st.startofpacket && !first_q)
                        err_d[1] = 1'b1;
                    if (cnt_q == LAST) begin
                        fend_d  = in_avl_st.endofpacket;
                        state_d = S_CRC;
                    end else if (in_avl_st.endofpacket) begin
                        err_d[0] = 1'b1;
                        fend_d   = 1'b1;
                        state_d  = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (free) begin
                    ld    = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = S_CRC;
                end
            end
            S_CRC: begin
                if (free) begin
                    ld       = 1'b1;
                    ld_data  = footer;
                    ld_eop   = 1'b1;
                    ld_empty = 2'd2;
                    state_d  = fend_q ? S_IDLE : S_HDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fend_q  <= 1'b0;
            first_q <= 1'b0;
            err_q   <= 2'b00;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fend_q  <= fend_d;
            first_q <= first_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odata_q  <= 32'h0;
            ovalid_q <= 1'b0;
            osop_q   <= 1'b0;
            oeop_q   <= 1'b0;
            oempty_q <= 2'd0;
        end else if (ld) begin
            odata_q  <= ld_data;
            ovalid_q <= 1'b1;
            osop_q   <= ld_sop;
            oeop_q   <= ld_eop;
            oempty_q <= ld_empty;
        end else if (free) begin
            ovalid_q <= 1'b0;
        end
    end

    assign in_avl_st.ready            = in_rdy;
    assign out_avl_st.data            = odata_q;
    assign out_avl_st.valid           = ovalid_q;
    assign out_avl_st.startofpacket   = osop_q;
    assign out_avl_st.endofpacket     = oeop_q;
    assign out_avl_st.empty           = oempty_q;
    assign err_flags                  = err_q;

endmodule
